// File: rtl/alu_sequencer.sv
// Command sequencer in front of the 8-bit ALU: registers operands, captures results into a FIFO.
// Optional accumulator chaining is enabled with `define ALU_SEQ_ACC_EN.
module alu_sequencer #(
    parameter int RES_DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic [1:0]                 cmd_op,
    input  logic [7:0]                 cmd_a,
    input  logic [7:0]                 cmd_b,
    input  logic                       cmd_use_acc,
    output logic [7:0]                 alu_a,
    output logic [7:0]                 alu_b,
    output logic [1:0]                 alu_opcode,
    input  logic [15:0]                alu_result,
    input  logic                       alu_zflag,
    output logic                       res_valid,
    input  logic                       res_ready,
    output logic [15:0]                res_data,
    output logic                       res_zero,
    output logic [$clog2(RES_DEPTH):0] res_count,
    output logic                       busy
);

    localparam int AW = $clog2(RES_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic {
        IDLE,
        EXEC
    } state_e;

    state_e          state_q, state_d;
    logic [7:0]      alu_a_q, alu_b_q;
    logic [1:0]      alu_op_q;
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]   count_q, count_d;
    logic [16:0]     mem_q [RES_DEPTH];
    logic            accept, push, pop;
    logic [7:0]      opa;

`ifdef ALU_SEQ_ACC_EN
    logic [7:0] acc_q;

    assign opa = cmd_use_acc ? acc_q : cmd_a;

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= 8'h00;
        end else if (push) begin
            acc_q <= alu_result[7:0];
        end
    end
`else
    logic unused_use_acc;

    assign unused_use_acc = cmd_use_acc;
    assign opa            = cmd_a;
`endif

    always_comb begin
        state_d   = state_q;
        cmd_ready = 1'b0;
        busy      = 1'b0;
        accept    = 1'b0;
        push      = 1'b0;
        case (state_q)
            IDLE: begin
                cmd_ready = !rst && (count_q < CW'(RES_DEPTH));
                accept    = cmd_valid && cmd_ready;
                if (accept) state_d = EXEC;
            end
            EXEC: begin
                busy    = 1'b1;
                push    = !rst;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign res_valid = (count_q != '0);
    assign pop       = res_valid && res_ready;

    // Admission only happens with a free slot, so a push never sees a full FIFO.
    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            alu_a_q  <= 8'h00;
            alu_b_q  <= 8'h00;
            alu_op_q <= 2'b00;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            if (accept) begin
                alu_a_q  <= opa;
                alu_b_q  <= cmd_b;
                alu_op_q <= cmd_op;
            end
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {alu_result, alu_zflag};
    end

    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_opcode = alu_op_q;
    assign res_data   = mem_q[rd_ptr_q][16:1];
    assign res_zero   = mem_q[rd_ptr_q][0];
    assign res_count  = count_q;

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Sequential front-end for the 8-bit combinational ALU: accepts operation commands over a valid/ready handshake, drives the ALU operand and opcode inputs from registers, and captures the 16-bit result and zero flag into a small result FIFO. The FIFO drains over a second valid/ready handshake. It sits between a command source (CPU or test stimulus) and the ALU, and is the initiator/consumer for that ALU's A/B/OpCode → Result/Zflag interface.

## Interface
Parameters:
- RES_DEPTH, 4, result FIFO entries; power of two, 2..16.

Ports:
- Clocking: one clock, `clk`. Reset is `rst`: synchronous and active-high.
- clk  input  1  clock; all state changes on rising edge.
- rst  input  1  synchronous reset, active-high.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  command accepted when cmd_valid && cmd_ready at a rising edge.
- cmd_op  input  2  00 add, 01 sub, 10 mul, 11 shift-left-by-1 of A.
- cmd_a  input  8  operand A.
- cmd_b  input  8  operand B.
- cmd_use_acc  input  1  take A from accumulator instead of cmd_a (see Configuration).
- alu_a  output  8  registered ALU operand A.
- alu_b  output  8  registered ALU operand B.
- alu_opcode  output  2  registered ALU opcode.
- alu_result  input  16  ALU result (combinational function of alu_a/alu_b/alu_opcode).
- alu_zflag  input  1  ALU zero flag.
- res_valid  output  1  FIFO non-empty.
- res_ready  input  1  consumer pops head when res_valid && res_ready at a rising edge.
- res_data  output  16  head result; don't-care while res_valid=0.
- res_zero  output  1  head zero flag; don't-care while res_valid=0.
- res_count  output  $clog2(RES_DEPTH)+1  FIFO occupancy.
- busy  output  1  high in EXEC.

## Operation
- FSM states: IDLE, EXEC.
- IDLE: cmd_ready = !rst && (res_count < RES_DEPTH). On accept: load alu_a (cmd_a, or acc if chaining), alu_b, alu_opcode; go to EXEC.
- EXEC: cmd_ready=0, busy=1. At the end of the cycle, push {alu_result, alu_zflag} into the FIFO; if chaining is compiled in, set acc = alu_result[7:0]; return to IDLE.
- alu_* registers hold their last values in IDLE. They change only on accept.
- Admission guarantees space. A push never occurs with a full FIFO, and no overflow path exists.
- Pop in the same cycle as a push: occupancy unchanged, and both take effect.
- Pop when empty: ignored.
- Result width rules are owned by the ALU and captured as-is:
  - sub underflow wraps in 16 bits (3−5 = 16'hFFFE);
  - shift is 16-bit (8'h81 → 16'h0102).
- Reset values: cmd_ready 0 during rst, 1 the cycle after; alu_a/alu_b/alu_opcode 0; res_valid 0; res_count 0; busy 0; acc 0; state IDLE. FIFO storage is not reset.
- Reset mid-operation: an in-flight EXEC command is dropped with no push, and all queued results are discarded.

## Timing
- Accept at edge k → alu_* valid after edge k → result pushed at edge k+1 → res_valid=1 after k+1 if FIFO was empty.
- Throughput: one command per 2 cycles. cmd_ready is low for exactly one cycle after each accept.
- cmd_ready is combinational from state, res_count and rst. res_valid, res_data and res_zero are driven from registers/FIFO head, with no combinational path from res_ready.
- ALU path: one full cycle from the alu_* registers through the ALU to the FIFO write.

## Configuration
- ALU_SEQ_ACC_EN defined:
  - 8-bit accumulator present;
  - cmd_use_acc=1 selects acc as operand A;
  - acc updates on every push.
- Undefined: no accumulator. cmd_use_acc is ignored and A always comes from cmd_a. The port remains.

## Test plan
- Reset, then add 3+5 with res_ready=1 → cmd_ready=1 after reset; res_valid rises 2 edges after accept; res_data=16'h0008, res_zero=0.
- sub 5−5 → 16'h0000, res_zero=1. sub 3−5 → 16'hFFFE, res_zero=0. mul 200×200 → 16'h9C40. shl A=8'h81 → 16'h0102.
- res_ready=0, issue 4 adds (RES_DEPTH=4) → res_count=4 and cmd_ready=0. Pop one → res_count=3 and cmd_ready=1. Pops return results in issue order.
- With ALU_SEQ_ACC_EN: add 3+5 (→8), then shl with cmd_use_acc=1, cmd_a=0 → 16'h0010. Without the macro, the same sequence → 16'h0000.
- Assert rst during EXEC with 2 results queued → next cycle res_valid=0, res_count=0, busy=0, alu_a=0; no result from the dropped command ever appears.
- Push and pop in the same cycle at res_count=2 → res_count stays 2, and the head advances to the next entry.
